// File: rtl/noc_pkg.sv
// Shared definitions for the on-chip packet network: width helpers,
// the flit layout and the flitizer FSM state type.
package noc_pkg;

  // Address width for a network of nodeCount nodes (at least one bit)
  function automatic int noc_node_w(input int nodeCount);
    return (nodeCount <= 1) ? 1 : $clog2(nodeCount);
  endfunction

  // Number of flits needed to carry a payload, rounding up
  function automatic int noc_flit_count(input int payload, input int flitPayload);
    return (payload + flitPayload - 1) / flitPayload;
  endfunction

  // Width of the flit index field (at least one bit)
  function automatic int noc_idx_w(input int flitCount);
    return (flitCount <= 1) ? 1 : $clog2(flitCount);
  endfunction

  // Total flit width: valid bit, two node addresses, index, data and id
  function automatic int noc_flit_w(input int nodeW, input int idxW,
                                    input int flitPayload, input int idW);
    return 1 + 2 * nodeW + idxW + flitPayload + idW;
  endfunction

  // Network-wide default configuration shared by flitizer and collector
  localparam int NOC_NODE_COUNT   = 8;
  localparam int NOC_ID_W         = 5;
  localparam int NOC_PAYLOAD      = 32;
  localparam int NOC_FLIT_PAYLOAD = 8;
  localparam int NOC_NODE_W       = noc_node_w(NOC_NODE_COUNT);
  localparam int NOC_FLIT_COUNT   = noc_flit_count(NOC_PAYLOAD, NOC_FLIT_PAYLOAD);
  localparam int NOC_IDX_W        = noc_idx_w(NOC_FLIT_COUNT);
  localparam int NOC_FLIT_W       = noc_flit_w(NOC_NODE_W, NOC_IDX_W,
                                               NOC_FLIT_PAYLOAD, NOC_ID_W);

  // Flit layout on the wire, MSB first
  typedef struct packed {
    logic                        valid_bit;
    logic [NOC_NODE_W-1:0]       node_dest;
    logic [NOC_IDX_W-1:0]        byte_index;
    logic [NOC_FLIT_PAYLOAD-1:0] data;
    logic [NOC_ID_W-1:0]         packet_id;
    logic [NOC_NODE_W-1:0]       node_start;
  } noc_flit_t;

  // Flitizer sequencing states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } flit_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Parameterized synchronous FIFO with clock enable and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. DEPTH must be a power of two >= 2.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doWrite;
  logic             doRead;

  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doWrite   = ce & wr_en_i & ~full_o;
  assign doRead    = ce & rd_en_i & ~empty_o;
  assign rd_data_o = mem[rdPtr_q[AW-1:0]];

  // Pointer advance on accepted writes and reads
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
    if (doRead)  rdPtr_d = rdPtr_q + 1'b1;
  end

  // Pointer registers, cleared to empty on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/packet_flitizer.sv
// Source-side packet serializer for the on-chip network.
// Accepts whole packets, tags each with a rolling id and emits them as a
// sequence of flits, MSB slice first.
// Build option PACKET_FLITIZER_FIFO_EN: adds a FIFO_DEPTH-entry input FIFO
// so packets stream back to back; without it a single packet register is
// used and one idle cycle separates consecutive packets.
module packet_flitizer
  import noc_pkg::*;
#(
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int PAYLOAD         = 32,
  parameter  int FLIT_PAYLOAD    = 8,
  parameter  int FIFO_DEPTH      = 4,
  localparam int NODE_W          = noc_node_w(NODE_COUNT),
  localparam int ID_W            = PACKET_ID_WIDTH,
  localparam int FLIT_COUNT      = noc_flit_count(PAYLOAD, FLIT_PAYLOAD),
  localparam int IDX_W           = noc_idx_w(FLIT_COUNT),
  localparam int FLIT_W          = noc_flit_w(NODE_W, IDX_W, FLIT_PAYLOAD, ID_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [NODE_W-1:0]  node_id,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [PAYLOAD-1:0] pkt_data,
  input  logic [NODE_W-1:0]  pkt_dest,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic [FLIT_W-1:0]  flit_out,
  output logic               busy
);

  // Payload is zero-padded at the LSB end up to a whole number of flits
  localparam int PADDED_W = FLIT_COUNT * FLIT_PAYLOAD;
  localparam int PAD_W    = PADDED_W - PAYLOAD;
  localparam int ENTRY_W  = PAYLOAD + NODE_W + ID_W;

  flit_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAYLOAD-1:0] curData_q, curData_d;
  logic [NODE_W-1:0]  curDest_q, curDest_d;
  logic [ID_W-1:0]    curId_q, curId_d;
  logic [ID_W-1:0]    idCount_q, idCount_d;

  logic               accept;
  logic               flitHs;
  logic               lastFlit;
  logic               loadPkt;
  logic [PAYLOAD-1:0] nextData;
  logic [NODE_W-1:0]  nextDest;
  logic [ID_W-1:0]    nextId;

  logic [PADDED_W-1:0]     padded;
  logic [PADDED_W-1:0]     shifted;
  logic [FLIT_PAYLOAD-1:0] flitData;

  assign flit_valid = (state_q == ST_SEND);
  assign accept     = pkt_valid & pkt_ready & ce;
  assign flitHs     = flit_valid & flit_ready & ce;
  assign lastFlit   = (idx_q == IDX_W'(FLIT_COUNT - 1));

`ifdef PACKET_FLITIZER_FIFO_EN
  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoWr;
  logic               fifoRd;
  logic               loadSlot;
  logic               bypass;
  logic [ENTRY_W-1:0] fifoRdData;

  // A new packet may be loaded whenever idle, or as the last flit leaves.
  // Queued packets go first; with an empty queue a packet arriving in the
  // same cycle skips the FIFO so an idle block starts sending next cycle.
  assign pkt_ready = ~fifoFull;
  assign loadSlot  = ce & ((state_q == ST_IDLE) | (flitHs & lastFlit));
  assign bypass    = loadSlot & fifoEmpty & accept;
  assign fifoWr    = accept & ~bypass;
  assign fifoRd    = loadSlot & ~fifoEmpty;
  assign loadPkt   = fifoRd | bypass;
  assign {nextData, nextDest, nextId} =
    fifoEmpty ? {pkt_data, pkt_dest, idCount_q} : fifoRdData;
  assign busy      = flit_valid | ~fifoEmpty;

  noc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uInFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .wr_en_i   (fifoWr),
    .wr_data_i ({pkt_data, pkt_dest, idCount_q}),
    .rd_en_i   (fifoRd),
    .rd_data_o (fifoRdData),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty)
  );
`else
  // Single packet register: packets are only taken while idle and go
  // straight into the sending registers
  assign pkt_ready = (state_q == ST_IDLE);
  assign loadPkt   = accept;
  assign nextData  = pkt_data;
  assign nextDest  = pkt_dest;
  assign nextId    = idCount_q;
  assign busy      = flit_valid;
`endif

  // Sequencing: load a packet, walk the flit index, chain or go idle
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    curData_d = curData_q;
    curDest_d = curDest_q;
    curId_d   = curId_q;
    idCount_d = accept ? idCount_q + 1'b1 : idCount_q;
    case (state_q)
      ST_IDLE: begin
        if (loadPkt) begin
          state_d   = ST_SEND;
          idx_d     = '0;
          curData_d = nextData;
          curDest_d = nextDest;
          curId_d   = nextId;
        end
      end
      ST_SEND: begin
        if (flitHs) begin
          if (!lastFlit) begin
            idx_d = idx_q + 1'b1;
          end else if (loadPkt) begin
            idx_d     = '0;
            curData_d = nextData;
            curDest_d = nextDest;
            curId_d   = nextId;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any partial packet and restarts ids at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      curData_q <= '0;
      curDest_q <= '0;
      curId_q   <= '0;
      idCount_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      curData_q <= curData_d;
      curDest_q <= curDest_d;
      curId_q   <= curId_d;
      idCount_q <= idCount_d;
    end
  end

  // Flit assembly: select the current slice and pack the header fields;
  // the bus reads all-zero whenever no flit is being offered
  always_comb begin
    padded   = PADDED_W'(curData_q) << PAD_W;
    shifted  = padded << (int'(idx_q) * FLIT_PAYLOAD);
    flitData = shifted[PADDED_W-1 -: FLIT_PAYLOAD];
    flit_out = '0;
    if (flit_valid) begin
      flit_out = {1'b1, curDest_q, idx_q, flitData, curId_q, node_id};
    end
  end

endmodule

// File: tb/tb_packet_flitizer.sv
// Self-checking bench for packet_flitizer. A reference model expands each
// accepted packet into its expected flits and compares every flit that the
// router side accepts; directed sections check timing and corner cases.
module tb_packet_flitizer;
  import noc_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        ce;
  logic [NOC_NODE_W-1:0]       node_id;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [NOC_PAYLOAD-1:0]      pkt_data;
  logic [NOC_NODE_W-1:0]       pkt_dest;
  logic                        flit_valid;
  logic                        flit_ready;
  logic [NOC_FLIT_W-1:0]       flit_out;
  logic                        busy;

  int checkCount = 0;
  int passCount  = 0;

  logic [NOC_FLIT_W-1:0] expQ [$];
  int                    modelId  = 0;
  logic                  prevHold = 1'b0;
  logic [NOC_FLIT_W-1:0] prevFlit = '0;
  logic [NOC_ID_W-1:0]   lastId   = '0;
  bit                    randReady = 1'b0;

  packet_flitizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .node_id    (node_id),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .pkt_dest   (pkt_dest),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_out   (flit_out),
    .busy       (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something never settles
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Expected flit k of a packet: byte k counted from the MSB end
  function automatic logic [NOC_FLIT_W-1:0] expFlit(input logic [NOC_PAYLOAD-1:0] d,
                                                    input logic [NOC_NODE_W-1:0] dst,
                                                    input logic [NOC_ID_W-1:0] id,
                                                    input int k);
    noc_flit_t f;
    logic [NOC_PAYLOAD-1:0] sh;
    sh           = d >> (NOC_FLIT_PAYLOAD * (NOC_FLIT_COUNT - 1 - k));
    f.valid_bit  = 1'b1;
    f.node_dest  = dst;
    f.byte_index = NOC_IDX_W'(k);
    f.data       = sh[NOC_FLIT_PAYLOAD-1:0];
    f.packet_id  = id;
    f.node_start = node_id;
    return f;
  endfunction

  // Reference model and stability monitor, sampled away from the clock edge
  always @(negedge clk) begin
    noc_flit_t fo;
    if (!rst_n) begin
      expQ.delete();
      modelId  = 0;
      prevHold = 1'b0;
    end else begin
      if (prevHold) checkOutput("holdStable", flit_out, prevFlit);
      if (flit_valid && flit_ready && ce) begin
        if (expQ.size() == 0) checkOutput("unexpectedFlit", flit_out, 0);
        else checkOutput("flitContent", flit_out, expQ.pop_front());
        fo     = noc_flit_t'(flit_out);
        lastId = fo.packet_id;
      end
      if (pkt_valid && pkt_ready && ce) begin
        for (int k = 0; k < NOC_FLIT_COUNT; k++)
          expQ.push_back(expFlit(pkt_data, pkt_dest, NOC_ID_W'(modelId), k));
        modelId = (modelId + 1) % (1 << NOC_ID_W);
      end
      prevHold = flit_valid && !(flit_ready && ce);
      prevFlit = flit_out;
    end
  end

  // Optional random router backpressure
  always @(posedge clk) begin
    if (randReady) begin
      #1;
      flit_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reset pulse spanning two edges; returns just after a rising edge
  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one packet and hold it until accepted; returns 1ns after the
  // accepting edge, i.e. in the first cycle after acceptance
  task automatic applyStimulus(input logic [NOC_PAYLOAD-1:0] d,
                               input logic [NOC_NODE_W-1:0] dst);
    bit done;
    done      = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = d;
    pkt_dest  = dst;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (pkt_ready && ce) done = 1'b1;
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    if (!done) checkOutput("acceptTimeout", 0, 1);
  endtask

  // Wait for the block to go quiet, then realign after a rising edge
  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !flit_valid) break;
    end
    checkOutput("drainBusy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] beefBytes [4];
  bit         validTrace [40];

  initial begin
    noc_flit_t f;
    logic [NOC_FLIT_W-1:0] snap;
    int firstV, lastV, cntV;

    beefBytes[0] = 8'hDE; beefBytes[1] = 8'hAD;
    beefBytes[2] = 8'hBE; beefBytes[3] = 8'hEF;

    rst_n      = 1'b0;
    ce         = 1'b1;
    node_id    = 3'd3;
    pkt_valid  = 1'b0;
    pkt_data   = '0;
    pkt_dest   = '0;
    flit_ready = 1'b1;

    // Reset state
    #12;
    checkOutput("reset.flitValid", flit_valid, 0);
    checkOutput("reset.flitOut", flit_out, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.pktReady", pkt_ready, 1);
    doReset();

    // Single packet, flit_ready high: flits in cycles N+1..N+4
    $display("[TB] single packet");
    applyStimulus(32'hDEADBEEF, 3'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      f = noc_flit_t'(flit_out);
      checkOutput("single.valid", flit_valid, 1);
      checkOutput("single.validBit", f.valid_bit, 1);
      checkOutput("single.index", f.byte_index, k);
      checkOutput("single.data", f.data, beefBytes[k]);
      checkOutput("single.id", f.packet_id, 0);
      checkOutput("single.start", f.node_start, 3);
      checkOutput("single.dest", f.node_dest, 5);
    end
    @(negedge clk);
    checkOutput("single.validFalls", flit_valid, 0);
    checkOutput("single.busyFalls", busy, 0);
    @(posedge clk);
    #1;

    // Backpressure during flit 2
    $display("[TB] backpressure");
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    flit_ready = 1'b0;
    snap = flit_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f = noc_flit_t'(flit_out);
      checkOutput("bp.held", flit_out, snap);
      checkOutput("bp.index", f.byte_index, 2);
    end
    @(posedge clk); #1;
    flit_ready = 1'b1;
    drain();

    // Back-to-back packets from reset
    $display("[TB] back-to-back");
    doReset();
    fork
      begin
        for (int p = 0; p < 4; p++) applyStimulus($urandom, 3'($urandom_range(0, 7)));
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          validTrace[i] = flit_valid;
        end
      end
    join
    firstV = -1; lastV = -1; cntV = 0;
    for (int i = 0; i < 40; i++) begin
      if (validTrace[i]) begin
        if (firstV < 0) firstV = i;
        lastV = i;
        cntV++;
      end
    end
    checkOutput("b2b.flitCycles", cntV, 16);
`ifdef PACKET_FLITIZER_FIFO_EN
    checkOutput("b2b.span", lastV - firstV + 1, 16);
`else
    checkOutput("b2b.span", lastV - firstV + 1, 19);
`endif
    checkOutput("b2b.firstCycle", firstV, 1);
    drain();

    // Input side stalls once storage is exhausted
    $display("[TB] ready drop");
    flit_ready = 1'b0;
`ifdef PACKET_FLITIZER_FIFO_EN
    for (int p = 0; p < 5; p++) applyStimulus($urandom, 3'($urandom_range(0, 7)));
`else
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
`endif
    @(negedge clk);
    checkOutput("full.pktReady", pkt_ready, 0);
    checkOutput("full.busy", busy, 1);
    @(posedge clk); #1;
    flit_ready = 1'b1;
    drain();

    // Clock enable low for two cycles mid-packet
    $display("[TB] clock enable");
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
    @(posedge clk); #1;
    ce        = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = $urandom;
    snap      = flit_out;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("ce.frozen", flit_out, snap);
      checkOutput("ce.busy", busy, 1);
    end
    @(posedge clk); #1;
    ce        = 1'b1;
    pkt_valid = 1'b0;
    @(negedge clk);
    f = noc_flit_t'(flit_out);
    checkOutput("ce.resume", flit_out, snap);
    checkOutput("ce.index", f.byte_index, 1);
    @(posedge clk); #1;
    drain();
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
    drain();

    // Reset while a packet is in flight
    $display("[TB] reset mid-packet");
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.flitValid", flit_valid, 0);
    checkOutput("rst.pktReady", pkt_ready, 1);
    checkOutput("rst.flitOut", flit_out, 0);
    checkOutput("rst.busy", busy, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus($urandom, 3'($urandom_range(0, 7)));
    @(negedge clk);
    f = noc_flit_t'(flit_out);
    checkOutput("rst.nextValid", flit_valid, 1);
    checkOutput("rst.nextIndex", f.byte_index, 0);
    checkOutput("rst.nextId", f.packet_id, 0);
    @(posedge clk); #1;
    drain();

    // Id wrap with random backpressure and destinations
    $display("[TB] id wrap");
    doReset();
    randReady = 1'b1;
    for (int p = 0; p < 33; p++) applyStimulus($urandom, 3'($urandom_range(0, 7)));
    drain();
    checkOutput("wrap.lastId", lastId, 0);
    randReady = 1'b0;
    @(posedge clk); #1;
    flit_ready = 1'b1;

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
